// File: rtl/dff_delay_line_if.sv
// Bundle for the delay line: control/data toward the pipeline on the master
// side, stage outputs back from the pipeline on the slave side.
interface dff_delay_line_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAPW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNTW  = $clog2(DEPTH + 1)
);
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [TAPW-1:0]  tap_sel;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             q_valid;
  logic [WIDTH-1:0] tap_q;
  logic             tap_valid;
  logic [CNTW-1:0]  fill;

  modport master (
    output en, clr, d, d_valid, tap_sel,
    input  q, qn, q_valid, tap_q, tap_valid, fill
  );

  modport slave (
    input  en, clr, d, d_valid, tap_sel,
    output q, qn, q_valid, tap_q, tap_valid, fill
  );
endinterface

// File: rtl/dff_delay_line.sv
// WIDTH x DEPTH clock-enabled delay line with a valid bit per stage,
// synchronous clear, a combinational tap and an occupancy count.

// One pipeline stage: data register plus its valid bit.
module dff_delay_line_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_v,
  output logic [WIDTH-1:0] o_q,
  output logic             o_v
);
  logic [WIDTH-1:0] r_q;
  logic             r_v;

  // Clear beats enable; data moves whether or not it is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      r_v <= 1'b0;
    end else if (i_clr) begin
      r_q <= '0;
      r_v <= 1'b0;
    end else if (i_en) begin
      r_q <= i_d;
      r_v <= i_v;
    end
  end

  assign o_q = r_q;
  assign o_v = r_v;
endmodule

module dff_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dff_delay_line_if.slave   bus
);
  localparam int TAPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] w_s;
  logic [DEPTH-1:0]            w_v;
  logic [WIDTH-1:0]            w_tap_q;
  logic                        w_tap_v;
  logic [CNTW-1:0]             w_fill;

  // Stage 0 takes the input port, every later stage takes its predecessor.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] w_din;
    logic             w_vin;
    if (i == 0) begin : g_head
      assign w_din = bus.d;
      assign w_vin = bus.d_valid;
    end else begin : g_body
      assign w_din = w_s[i-1];
      assign w_vin = w_v[i-1];
    end
    dff_delay_line_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (bus.en),
      .i_clr (bus.clr),
      .i_d   (w_din),
      .i_v   (w_vin),
      .o_q   (w_s[i]),
      .o_v   (w_v[i])
    );
  end

  // Tap mux; out-of-range selects fall back to the last stage.
  always_comb begin
    w_tap_q = w_s[DEPTH-1];
    w_tap_v = w_v[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.tap_sel == TAPW'(i)) begin
        w_tap_q = w_s[i];
        w_tap_v = w_v[i];
      end
    end
  end

  // Occupancy: popcount of the registered valid bits, so at most DEPTH.
  always_comb begin
    w_fill = '0;
    for (int i = 0; i < DEPTH; i++) w_fill = w_fill + CNTW'(w_v[i]);
  end

  assign bus.q         = w_s[DEPTH-1];
  assign bus.qn        = ~w_s[DEPTH-1];
  assign bus.q_valid   = w_v[DEPTH-1];
  assign bus.tap_q     = w_tap_q;
  assign bus.tap_valid = w_tap_v;
  assign bus.fill      = w_fill;
endmodule
